// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with storage, occupancy count, threshold flags and registered read data.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
`endif
);

  localparam int CNT_W = PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if ((1 << PTR_WIDTH) != DEPTH) begin : g_bad_ptr_width
    $error("sync_fifo_ctrl: PTR_WIDTH must equal log2(DEPTH)");
  end
  if (DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be at least 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("sync_fifo_ctrl: threshold out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_acc, rd_acc;

  // Flags decode straight from the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign d_out        = d_out_q;
  assign rd_valid     = rd_valid_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    d_out_d    = d_out_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      d_out_d  = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      d_out_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      d_out_q    <= d_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is not reset, but a write in a reset cycle is still suppressed.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= d_in;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A new error event beats a clear issued in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (DATA_WIDTH=8, DEPTH=16, AF=14, AE=2).
// Covers SYNC_FIFO_ERR_EN flags when that macro is defined.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] d_in;
  logic       rd_en;
  logic [7:0] d_out;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow, underflow, err_clr;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = 8'h00;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_dout", 32'(d_out), 0);
    check("rst_valid", 32'(rd_valid), 0);

    // fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; d_in = 8'(i);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_af", 32'(almost_full), (i >= 14) ? 1 : 0);
      check("fill_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check("fill_full", 32'(full), (i == 16) ? 1 : 0);
    end

    // write to full is dropped
    d_in = 8'hAA;
    step();
    wr_en = 1'b0;
    check("ovf_count", 32'(count), 16);
    check("ovf_full", 32'(full), 1);
    check("ovf_valid", 32'(rd_valid), 0);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_flag", 32'(overflow), 1);
    step();
    check("ovf_sticky", 32'(overflow), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
`endif

    // simultaneous access while full: only the read happens
    wr_en = 1'b1; rd_en = 1'b1; d_in = 8'hBB;
    step();
    wr_en = 1'b0;
    check("fullrw_dout", 32'(d_out), 32'h01);
    check("fullrw_valid", 32'(rd_valid), 1);
    check("fullrw_count", 32'(count), 15);

    // drain remaining words in order
    for (int i = 2; i <= 16; i++) begin
      step();
      check("drain_dout", 32'(d_out), 32'(i));
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_count", 32'(count), 32'(16 - i));
    end
    check("drain_empty", 32'(empty), 1);

    // read from empty is dropped, d_out holds
    step();
    rd_en = 1'b0;
    check("udf_valid", 32'(rd_valid), 0);
    check("udf_dout", 32'(d_out), 32'h10);
    check("udf_count", 32'(count), 0);
`ifdef SYNC_FIFO_ERR_EN
    check("udf_flag", 32'(underflow), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("udf_clr", 32'(underflow), 0);
`endif
    step();
    check("idle_valid", 32'(rd_valid), 0);

    // simultaneous access while empty: only the write happens
    wr_en = 1'b1; rd_en = 1'b1; d_in = 8'h55;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("emprw_count", 32'(count), 1);
    check("emprw_valid", 32'(rd_valid), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("emprw_dout", 32'(d_out), 32'h55);
    check("emprw_valid2", 32'(rd_valid), 1);
    check("emprw_count2", 32'(count), 0);

    // count=5 then 40 cycles of streaming across pointer wrap
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; d_in = 8'(8'h20 + i);
      step();
    end
    check("pre_stream_count", 32'(count), 5);
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d_in = 8'(8'h25 + k);
      step();
      check("stream_count", 32'(count), 5);
      check("stream_dout", 32'(d_out), 32'(8'h20 + k));
      check("stream_valid", 32'(rd_valid), 1);
    end
    rd_en = 1'b0;

    // grow to 9, then reset with a concurrent write
    for (int i = 0; i < 4; i++) begin
      d_in = 8'(8'h60 + i);
      step();
    end
    check("pre_rst_count", 32'(count), 9);
    rst = 1'b1; d_in = 8'h77; rd_en = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("rst2_count", 32'(count), 0);
    check("rst2_empty", 32'(empty), 1);
    check("rst2_dout", 32'(d_out), 0);
    check("rst2_valid", 32'(rd_valid), 0);

    wr_en = 1'b1; d_in = 8'h3C;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_dout", 32'(d_out), 32'h3C);
    check("post_rst_valid", 32'(rd_valid), 1);
    check("post_rst_count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
